hkspi_regif: RTL and testbench

//  Parametrised housekeeping-SPI slave with a register-access engine, all in the wb_clk_i domain.

---
 rtl/hkspi_pkg.sv | 22 ++
 rtl/hkspi_sync.sv | 27 ++
 rtl/hkspi_regif.sv | 163 ++++++++++++++++
 tb/tb_hkspi_regif.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hkspi_pkg.sv
// Shared types and command-byte field positions for the housekeeping SPI register interface.
package hkspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } hk_state_e;

    localparam int CMD_WR_BIT  = 7;
    localparam int CMD_RD_BIT  = 6;
    localparam int CMD_CNT_MSB = 5;
    localparam int CMD_CNT_LSB = 3;

    // Byte count carried in the command; zero means stream until chip select rises.
    function automatic logic [2:0] cmd_count(input logic [7:0] cmd);
        return cmd[CMD_CNT_MSB:CMD_CNT_LSB];
    endfunction

endpackage

// File: rtl/hkspi_sync.sv
// Multi-flop synchroniser for one asynchronous pad input, with single-cycle rise/fall pulses.
module hkspi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_reg;
    logic              prev_reg;

    // The chain keeps tracking the pin through reset, so a level held across reset
    // release never shows up as an edge afterwards.
    always_ff @(posedge clk) begin
        chain_reg <= {chain_reg[STAGES-2:0], din};
        prev_reg  <= chain_reg[STAGES-1];
    end

    assign dout = chain_reg[STAGES-1];
    assign rise = !srst &&  chain_reg[STAGES-1] && !prev_reg;
    assign fall = !srst && !chain_reg[STAGES-1] &&  prev_reg;

endmodule

// File: rtl/hkspi_regif.sv
// Housekeeping SPI slave (mode 0, oversampled) driving a byte-wide register port with auto-increment.
// Optional HKSPI_ERR_CNT_EN adds err_cnt_o, a saturating count of partial-byte / out-of-range-write transactions.
module hkspi_regif
    import hkspi_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int NUM_REGS    = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              spi_sck_i,
    input  logic              spi_csb_i,
    input  logic              spi_sdi_i,
    output logic              spi_sdo_o,
    output logic              spi_sdo_oe_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [7:0]        reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [7:0]        reg_rdata_i,
    output logic              busy_o
`ifdef HKSPI_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt_o
`endif
);

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NUM_REGS_W;
    endfunction

    hk_state_e         state_reg;
    logic [2:0]        bit_cnt_reg, byte_cnt_reg, cnt_reg;
    logic [6:0]        rx_reg;
    logic [7:0]        tx_reg, wdata_reg, rx_byte;
    logic [ADDR_W-1:0] addr_reg;
    logic              cmd_wr_reg, cmd_rd_reg, we_reg, re_reg, fetch_reg, step_reg, busy_reg;
    logic              sck_rise, sck_fall, csb_s, csb_rise, csb_fall, sdi_s;
    logic              active, byte_end;

    hkspi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(wb_clk_i), .srst(wb_rst_i), .din(spi_sck_i), .dout(), .rise(sck_rise), .fall(sck_fall)
    );
    hkspi_sync #(.STAGES(SYNC_STAGES)) u_sync_csb (
        .clk(wb_clk_i), .srst(wb_rst_i), .din(spi_csb_i), .dout(csb_s), .rise(csb_rise), .fall(csb_fall)
    );
    hkspi_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(wb_clk_i), .srst(wb_rst_i), .din(spi_sdi_i), .dout(sdi_s), .rise(), .fall()
    );

    assign rx_byte  = {rx_reg, sdi_s};
    assign active   = state_reg inside {ST_CMD, ST_ADDR, ST_DATA};
    assign byte_end = active && sck_rise && (bit_cnt_reg == 3'd7) && !csb_rise && !csb_fall;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            cnt_reg      <= '0;
            rx_reg       <= '0;
            tx_reg       <= '0;
            wdata_reg    <= '0;
            addr_reg     <= '0;
            cmd_wr_reg   <= 1'b0;
            cmd_rd_reg   <= 1'b0;
            we_reg       <= 1'b0;
            re_reg       <= 1'b0;
            fetch_reg    <= 1'b0;
            step_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            we_reg    <= 1'b0;
            re_reg    <= 1'b0;
            step_reg  <= 1'b0;
            fetch_reg <= re_reg;
            busy_reg  <= !csb_s;

            // Read data arrives the cycle after the strobe; unimplemented addresses read as zero.
            if (fetch_reg)
                tx_reg <= addr_ok(addr_reg) ? reg_rdata_i : 8'h00;

            // Increment one cycle after the write strobe so we and re never overlap.
            if (step_reg) begin
                addr_reg <= addr_reg + 1'b1;
                re_reg   <= cmd_rd_reg && (state_reg == ST_DATA);
            end

            if (csb_rise) begin
                state_reg   <= ST_IDLE;
                bit_cnt_reg <= '0;
            end else if (csb_fall) begin
                state_reg    <= ST_CMD;
                bit_cnt_reg  <= '0;
                byte_cnt_reg <= '0;
                cmd_wr_reg   <= 1'b0;
                cmd_rd_reg   <= 1'b0;
            end else if (active && sck_rise) begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                rx_reg      <= rx_byte[6:0];
                if (bit_cnt_reg == 3'd7) begin
                    case (state_reg)
                        ST_CMD: begin
                            cmd_wr_reg <= rx_byte[CMD_WR_BIT];
                            cmd_rd_reg <= rx_byte[CMD_RD_BIT];
                            cnt_reg    <= cmd_count(rx_byte);
                            state_reg  <= (rx_byte[CMD_WR_BIT] || rx_byte[CMD_RD_BIT]) ? ST_ADDR : ST_DONE;
                        end
                        ST_ADDR: begin
                            addr_reg  <= ADDR_W'(rx_byte);
                            re_reg    <= cmd_rd_reg;
                            state_reg <= ST_DATA;
                        end
                        default: begin
                            we_reg       <= cmd_wr_reg && addr_ok(addr_reg);
                            wdata_reg    <= rx_byte;
                            step_reg     <= 1'b1;
                            byte_cnt_reg <= byte_cnt_reg + 3'd1;
                            if ((cnt_reg != 3'd0) && (byte_cnt_reg + 3'd1 == cnt_reg))
                                state_reg <= ST_DONE;
                        end
                    endcase
                end
            end else if (active && sck_fall && (bit_cnt_reg != 3'd0)) begin
                // The MSB of a freshly fetched byte is already in place; only shift mid-byte.
                tx_reg <= {tx_reg[6:0], 1'b0};
            end
        end
    end

`ifdef HKSPI_ERR_CNT_EN
    logic [7:0] err_cnt_reg;
    logic       oor_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            err_cnt_reg <= '0;
            oor_reg     <= 1'b0;
        end else begin
            if (csb_fall)
                oor_reg <= 1'b0;
            else if (byte_end && (state_reg == ST_DATA) && cmd_wr_reg && !addr_ok(addr_reg))
                oor_reg <= 1'b1;
            if (csb_rise && ((bit_cnt_reg != 3'd0) || oor_reg) && (err_cnt_reg != 8'hFF))
                err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_reg;
`endif

    assign spi_sdo_oe_o = (state_reg == ST_DATA) && cmd_rd_reg;
    assign spi_sdo_o    = spi_sdo_oe_o && tx_reg[7];
    assign reg_addr_o   = addr_reg;
    assign reg_wdata_o  = wdata_reg;
    assign reg_we_o     = we_reg;
    assign reg_re_o     = re_reg;
    assign busy_o       = busy_reg;

endmodule

// File: tb/tb_hkspi_regif.sv
// Self-checking bench for hkspi_regif: bit-banged SPI master, register-file responder, reference model.
module tb_hkspi_regif;

    localparam int HALF = 6;
    localparam int NREG = 19;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       sck = 1'b0, csb = 1'b1, sdi = 1'b0;
    logic       sdo, oe, we, re, busy;
    logic [7:0] addr, wdata;
    logic [7:0] rdata = 8'h00;
`ifdef HKSPI_ERR_CNT_EN
    logic [7:0] err_cnt;
    int         err_exp = 0;
`endif

    always #5 clk = ~clk;

    hkspi_regif dut (
        .wb_clk_i(clk), .wb_rst_i(srst),
        .spi_sck_i(sck), .spi_csb_i(csb), .spi_sdi_i(sdi),
        .spi_sdo_o(sdo), .spi_sdo_oe_o(oe),
        .reg_addr_o(addr), .reg_wdata_o(wdata), .reg_we_o(we), .reg_re_o(re),
        .reg_rdata_i(rdata), .busy_o(busy)
`ifdef HKSPI_ERR_CNT_EN
        , .err_cnt_o(err_cnt)
`endif
    );

    logic [7:0]  regfile [256];
    logic [7:0]  ref_regs [256];
    logic [15:0] we_q[$];
    logic [7:0]  re_q[$];
    logic [7:0]  txq[$];
    logic [7:0]  rx_q[$];
    logic        oe_any_q[$], oe_all_q[$];
    logic        both_seen = 1'b0;
    int          chk_cnt = 0, pass_cnt = 0;

    // Register-file responder and strobe monitor; returns junk for unimplemented addresses.
    always @(negedge clk) begin
        if (re) begin
            rdata = (addr < NREG) ? regfile[addr] : 8'hA5;
            re_q.push_back(addr);
        end
        if (we) begin
            regfile[addr] = wdata;
            we_q.push_back({addr, wdata});
        end
        if (we && re) both_seen = 1'b1;
    end

    task automatic add(input logic [7:0] b);
        txq.push_back(b);
    endtask

    task automatic spi_bits(input logic [7:0] m, input int nb, output logic [7:0] r,
                            output logic any_oe, output logic all_oe);
        r = 8'h00; any_oe = 1'b0; all_oe = 1'b1;
        for (int i = 7; i > 7 - nb; i--) begin
            sdi = m[i];
            repeat (HALF) @(negedge clk);
            r[i] = sdo; any_oe = any_oe | oe; all_oe = all_oe & oe;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic spi_txn(input string tag, input int last_bits);
        logic [7:0] r;
        logic       a, l;
        int         nb;
        rx_q.delete(); oe_any_q.delete(); oe_all_q.delete();
        csb = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < txq.size(); k++) begin
            nb = (k == txq.size() - 1) ? last_bits : 8;
            spi_bits(txq[k], nb, r, a, l);
            rx_q.push_back(r); oe_any_q.push_back(a); oe_all_q.push_back(l);
        end
        repeat (HALF) @(negedge clk);
        csb = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        $display("txn %s: cmd=%02h bytes=%0d last_bits=%0d", tag, txq[0], txq.size(), last_bits);
    endtask

    task automatic test_reset();
        chk_cnt++;
        if ({sdo, oe, we, re, busy, addr, wdata} !== 21'h0)
            $display("FAIL reset_outputs got=%h exp=0", {sdo, oe, we, re, busy, addr, wdata});
        else pass_cnt++;
`ifdef HKSPI_ERR_CNT_EN
        chk_cnt++;
        if (err_cnt !== 8'h00) $display("FAIL reset_err_cnt got=%h exp=00", err_cnt); else pass_cnt++;
`endif
    endtask

    task automatic test_read_single();
        int n3 = 0;
        re_q.delete();
        txq.delete(); add(8'h40); add(8'h03); add(8'h00);
        spi_txn("read1", 8);
        foreach (re_q[i]) if (re_q[i] == 8'h03) n3++;
        chk_cnt++;
        if (rx_q[2] !== ref_regs[3]) $display("FAIL read1_data got=%h exp=%h", rx_q[2], ref_regs[3]); else pass_cnt++;
        chk_cnt++;
        if (n3 !== 1) $display("FAIL read1_re_count got=%0d exp=1", n3); else pass_cnt++;
        chk_cnt++;
        if ({oe_any_q[1], oe_all_q[2]} !== 2'b01)
            $display("FAIL read1_oe got=%b exp=01", {oe_any_q[1], oe_all_q[2]});
        else pass_cnt++;
    endtask

    task automatic test_write_twice();
        logic [15:0] w0, w1;
        we_q.delete();
        txq.delete(); add(8'h80); add(8'h0b); add(8'h01); spi_txn("write_a", 8);
        txq.delete(); add(8'h80); add(8'h0b); add(8'h00); spi_txn("write_b", 8);
        ref_regs[8'h0b] = 8'h00;
        w0 = (we_q.size() > 0) ? we_q[0] : 16'hFFFF;
        w1 = (we_q.size() > 1) ? we_q[1] : 16'hFFFF;
        chk_cnt++;
        if (we_q.size() !== 2) $display("FAIL write2_count got=%0d exp=2", we_q.size()); else pass_cnt++;
        chk_cnt++;
        if ({w0, w1} !== 32'h0b01_0b00) $display("FAIL write2_data got=%h exp=0b010b00", {w0, w1}); else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [7:0] e;
        txq.delete(); add(8'h40); add(8'h00);
        for (int i = 0; i < 20; i++) add(8'h00);
        spi_txn("stream20", 8);
        for (int i = 0; i < 20; i++) begin
            e = (i < NREG) ? ref_regs[i] : 8'h00;
            chk_cnt++;
            if (rx_q[2 + i] !== e) $display("FAIL stream_byte%0d got=%h exp=%h", i, rx_q[2 + i], e); else pass_cnt++;
        end
    endtask

    task automatic test_fixed_count();
        re_q.delete();
        txq.delete(); add(8'h50); add(8'h01); add(8'h00); add(8'h00); add(8'h00);
        spi_txn("read_n2", 8);
        chk_cnt++;
        if ({rx_q[2], rx_q[3]} !== {ref_regs[1], ref_regs[2]})
            $display("FAIL fixed_data got=%h exp=%h", {rx_q[2], rx_q[3]}, {ref_regs[1], ref_regs[2]});
        else pass_cnt++;
        chk_cnt++;
        if ({rx_q[4], oe_any_q[4]} !== 9'h0) $display("FAIL fixed_done_sdo got=%h/%b exp=00/0", rx_q[4], oe_any_q[4]); else pass_cnt++;
        chk_cnt++;
        if (re_q.size() !== 2) $display("FAIL fixed_re_count got=%0d exp=2", re_q.size()); else pass_cnt++;
    endtask

    task automatic test_partial();
        we_q.delete();
        txq.delete(); add(8'h80); add(8'h05); add(8'hAA);
        spi_txn("partial", 5);
        chk_cnt++;
        if (we_q.size() !== 0) $display("FAIL partial_we got=%0d exp=0", we_q.size()); else pass_cnt++;
`ifdef HKSPI_ERR_CNT_EN
        err_exp++;
        chk_cnt++;
        if (err_cnt !== 8'(err_exp)) $display("FAIL partial_err_cnt got=%0d exp=%0d", err_cnt, err_exp); else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        logic       a, l;
        we_q.delete(); re_q.delete();
        csb = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(8'h80, 8, r, a, l); spi_bits(8'h07, 8, r, a, l); spi_bits(8'hFF, 3, r, a, l);
        srst = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({sdo, oe, we, re, busy, addr, wdata} !== 21'h0)
            $display("FAIL rstmid_outputs got=%h exp=0", {sdo, oe, we, re, busy, addr, wdata});
        else pass_cnt++;
        spi_bits(8'hFF, 4, r, a, l);
        chk_cnt++;
        if ({sdo, oe, we, re, busy, addr, wdata, we_q.size() == 0} !== 22'h1)
            $display("FAIL rstmid_held got=%h exp=1", {sdo, oe, we, re, busy, addr, wdata, we_q.size() == 0});
        else pass_cnt++;
        srst = 1'b0;
`ifdef HKSPI_ERR_CNT_EN
        err_exp = 0;
`endif
        repeat (2) @(negedge clk);
        spi_bits(8'h40, 8, r, a, l); spi_bits(8'h03, 8, r, a, l); spi_bits(8'h00, 8, r, a, l);
        chk_cnt++;
        if ({we_q.size() == 0, re_q.size() == 0, a} !== 3'b110)
            $display("FAIL rstmid_ignored got=%0d/%0d/%b exp=0/0/0", we_q.size(), re_q.size(), a);
        else pass_cnt++;
        repeat (HALF) @(negedge clk);
        csb = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        txq.delete(); add(8'h40); add(8'h03); add(8'h00);
        spi_txn("read_after_rst", 8);
        chk_cnt++;
        if (rx_q[2] !== ref_regs[3]) $display("FAIL rstmid_read got=%h exp=%h", rx_q[2], ref_regs[3]); else pass_cnt++;
    endtask

    task automatic test_read_write();
        logic [7:0]  a, ad, e;
        logic [7:0]  d[3];
        logic [15:0] exp_q[$];
        int          bad;
        logic        oor = 1'b0;
        a = 8'($urandom_range(14, 18));
        we_q.delete();
        txq.delete(); add(8'hC0); add(a);
        for (int i = 0; i < 3; i++) begin d[i] = 8'($urandom); add(d[i]); end
        spi_txn("rw", 8);
        for (int i = 0; i < 3; i++) begin
            ad = a + 8'(i);
            e = (ad < NREG) ? ref_regs[ad] : 8'h00;
            chk_cnt++;
            if (rx_q[2 + i] !== e) $display("FAIL rw_read%0d got=%h exp=%h", i, rx_q[2 + i], e); else pass_cnt++;
            if (ad < NREG) begin ref_regs[ad] = d[i]; exp_q.push_back({ad, d[i]}); end
            else oor = 1'b1;
        end
        bad = (we_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_q[i]) if (we_q[i] !== exp_q[i]) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL rw_writes got=%0d entries exp=%0d (%0d differ)", we_q.size(), exp_q.size(), bad); else pass_cnt++;
`ifdef HKSPI_ERR_CNT_EN
        if (oor && err_exp < 255) err_exp++;
`else
        if (oor) bad = 0;
`endif
    endtask

    task automatic test_random();
        logic [7:0]  a, ad, e;
        logic [7:0]  d[4];
        logic [15:0] exp_q[$];
        int          n, len, bad;
        logic        oor;
        for (int it = 0; it < 6; it++) begin
            exp_q.delete(); oor = 1'b0;
            n   = $urandom_range(0, 3);
            len = (n == 0) ? $urandom_range(1, 4) : n;
            a   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 22));
            txq.delete(); add(8'h80 | 8'(n << 3)); add(a);
            for (int i = 0; i < len; i++) begin
                d[i] = 8'($urandom); add(d[i]);
                ad = a + 8'(i);
                if (ad < NREG) begin ref_regs[ad] = d[i]; exp_q.push_back({ad, d[i]}); end
                else oor = 1'b1;
            end
            we_q.delete();
            spi_txn("rand_wr", 8);
            bad = (we_q.size() != exp_q.size()) ? 1 : 0;
            if (bad == 0) foreach (exp_q[i]) if (we_q[i] !== exp_q[i]) bad++;
            chk_cnt++;
            if (bad != 0) $display("FAIL rand%0d_writes got=%0d entries exp=%0d (%0d differ)", it, we_q.size(), exp_q.size(), bad); else pass_cnt++;
`ifdef HKSPI_ERR_CNT_EN
            if (oor && err_exp < 255) err_exp++;
`endif
            txq.delete(); add(8'h40 | 8'(len << 3)); add(a);
            for (int i = 0; i < len; i++) add(8'h00);
            spi_txn("rand_rd", 8);
            for (int i = 0; i < len; i++) begin
                ad = a + 8'(i);
                e = (ad < NREG) ? ref_regs[ad] : 8'h00;
                chk_cnt++;
                if (rx_q[2 + i] !== e) $display("FAIL rand%0d_read%0d addr=%h got=%h exp=%h", it, i, ad, rx_q[2 + i], e); else pass_cnt++;
            end
        end
    endtask

    task automatic test_final();
        chk_cnt++;
        if (both_seen !== 1'b0) $display("FAIL we_re_overlap got=1 exp=0"); else pass_cnt++;
`ifdef HKSPI_ERR_CNT_EN
        chk_cnt++;
        if (err_cnt !== 8'(err_exp)) $display("FAIL final_err_cnt got=%0d exp=%0d", err_cnt, err_exp); else pass_cnt++;
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            regfile[i]  = 8'($urandom);
            ref_regs[i] = regfile[i];
        end
        regfile[1] = 8'h04; regfile[2] = 8'h56; regfile[3] = 8'h11;
        ref_regs[1] = 8'h04; ref_regs[2] = 8'h56; ref_regs[3] = 8'h11;
        repeat (5) @(negedge clk);
        test_reset();
        srst = 1'b0;
        repeat (4) @(negedge clk);
        test_read_single();
        test_write_twice();
        test_stream();
        test_fixed_count();
        test_partial();
        test_reset_mid();
        test_read_write();
        test_random();
        test_final();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
